// File: rtl/wb_bus_if.sv
// Wishbone B4 classic master bridge: turns a single-cycle core memory request
// into one bus transaction and stalls the pipeline until the slave acks.
module wb_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall_i,
    input  logic                flush_i,
    input  logic                cpu_ce_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    input  logic                cpu_we_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq_o,
    input  logic [DATA_W-1:0]   wb_data_i,
    input  logic                wb_ack_i,
    output logic [ADDR_W-1:0]   wb_addr_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o
);

    // state          | meaning
    // IDLE           | no transaction; accepts a core request
    // BUSY           | stb/cyc asserted, waiting for wb_ack_i
    // WAIT_FOR_STALL | acked, pipeline still frozen elsewhere; rd_buf drives cpu_data_o
    localparam logic [1:0] IDLE           = 2'd0;
    localparam logic [1:0] BUSY           = 2'd1;
    localparam logic [1:0] WAIT_FOR_STALL = 2'd2;

    localparam int SEL_W = DATA_W / 8;

    logic [1:0]        state;
    logic [DATA_W-1:0] rd_buf;
    logic              stall_any;

    assign stall_any = |stall_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wb_addr_o <= '0;
            wb_data_o <= '0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            rd_buf    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        wb_addr_o <= cpu_addr_i;
                        wb_data_o <= cpu_data_i;
                        wb_we_o   <= cpu_we_i;
                        wb_sel_o  <= cpu_sel_i;
                        wb_stb_o  <= 1'b1;
                        wb_cyc_o  <= 1'b1;
                        rd_buf    <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // flush beats a same-cycle ack so an aborted read never lands in rd_buf
                    if (flush_i || wb_ack_i) begin
                        wb_addr_o <= '0;
                        wb_data_o <= '0;
                        wb_we_o   <= 1'b0;
                        wb_sel_o  <= '0;
                        wb_stb_o  <= 1'b0;
                        wb_cyc_o  <= 1'b0;
                    end
                    if (flush_i) begin
                        rd_buf <= '0;
                        state  <= IDLE;
                    end else if (wb_ack_i) begin
                        if (!wb_we_o) begin
                            rd_buf <= wb_data_i;
                        end
                        state <= stall_any ? WAIT_FOR_STALL : IDLE;
                    end
                end
                WAIT_FOR_STALL: begin
                    if (flush_i) begin
                        rd_buf <= '0;
                        state  <= IDLE;
                    end else if (!stall_any) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        if (!rst) begin
            case (state)
                IDLE: stallreq_o = cpu_ce_i & ~flush_i;
                BUSY: begin
                    if (!flush_i) begin
                        if (wb_ack_i) begin
                            cpu_data_o = wb_we_o ? '0 : wb_data_i;
                        end else begin
                            stallreq_o = 1'b1;
                        end
                    end
                end
                WAIT_FOR_STALL: cpu_data_o = rd_buf;
                default: begin
                    stallreq_o = 1'b0;
                    cpu_data_o = '0;
                end
            endcase
        end
    end

    logic unused_sel_w;
    assign unused_sel_w = (SEL_W == 0);

endmodule

// File: doc/wb_bus_if.md
Name: wb_bus_if

Overview:
- Wishbone B4 classic master bridge between one core memory port and the external bus.
- One instance sits on the instruction port, immediately upstream of the core's rom_data_i/rom_addr_o/rom_ce_o.
- A second instance sits on the data port.
- Converts the core's single-cycle combinational memory request into a multi-cycle bus transaction, and holds the pipeline via stallreq_o until ack.

Parameters:
- ADDR_W, 32, address width of core and bus.
- DATA_W, 32, data width; byte select width is DATA_W/8.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- stall_i  input  6  pipeline stall vector from ctrl; any nonzero bit means the pipeline is frozen
- flush_i  input  1  abort current request (tied 0 until exceptions exist)
- cpu_ce_i  input  1  core request valid
- cpu_addr_i  input  ADDR_W  request address
- cpu_data_i  input  DATA_W  write data
- cpu_we_i  input  1  1 = write, 0 = read
- cpu_sel_i  input  DATA_W/8  byte enables
- cpu_data_o  output  DATA_W  read data to core
- stallreq_o  output  1  stall request to ctrl
- wb_data_i  input  DATA_W  bus read data
- wb_ack_i  input  1  bus acknowledge
- wb_addr_o  output  ADDR_W  bus address
- wb_data_o  output  DATA_W  bus write data
- wb_we_o  output  1  bus write enable
- wb_sel_o  output  DATA_W/8  bus byte selects
- wb_stb_o  output  1  strobe
- wb_cyc_o  output  1  cycle

Behaviour:
- Reset: asynchronous, active-high. Clock port is clk and reset port is rst, matching the rest of the core.
  - State goes to IDLE.
  - All wb_*_o outputs are registered and reset to 0.
  - The internal read buffer rd_buf resets to 0.
- Combinational outputs: cpu_data_o and stallreq_o. Both are 0 while rst=1.
- FSM states: IDLE, BUSY, WAIT_FOR_STALL.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0:
    - Register wb_addr_o<=cpu_addr_i, wb_data_o<=cpu_data_i, wb_we_o<=cpu_we_i, wb_sel_o<=cpu_sel_i.
    - Set wb_stb_o=wb_cyc_o<=1.
    - Clear rd_buf<=0 and go to BUSY.
  - stallreq_o = cpu_ce_i & ~flush_i.
  - cpu_data_o = 0.
- BUSY:
  - flush_i=1 takes priority over ack. Deassert stb/cyc, zero addr/data/we/sel, clear rd_buf, go to IDLE. stallreq_o=0.
  - wb_ack_i=1:
    - Deassert stb/cyc and zero addr/data/we/sel.
    - If wb_we_o=0, set rd_buf<=wb_data_i.
    - Next state is WAIT_FOR_STALL if stall_i!=0, else IDLE.
    - In the same cycle, stallreq_o=0 and cpu_data_o=wb_data_i for reads (0 for writes).
  - wb_ack_i=0: stallreq_o=1, cpu_data_o=0, outputs held stable.
- WAIT_FOR_STALL:
  - Covers the case where the pipeline is still frozen by another source after ack.
  - stallreq_o=0, cpu_data_o=rd_buf.
  - Go to IDLE when stall_i==0.
  - flush_i=1 also returns to IDLE and clears rd_buf.
- Bus rules:
  - Exactly one outstanding transaction; no pipelining.
  - stb and cyc are always equal.
  - addr/data/we/sel are stable for the whole time stb=1.
  - wb_ack_i outside BUSY is ignored.
- Latency: a zero-wait-state slave (ack in the first BUSY cycle) costs 1 stall cycle per access.
- Reset mid-transaction: returns to IDLE immediately and drops stb/cyc asynchronously. The slave must tolerate the aborted cycle.
- Request-change rule: cpu_addr_i changes while BUSY are not sampled, because the core is stalled and its inputs must be stable.

Test Plan:
- Reset with rst=1 in mid-BUSY → wb_stb_o=wb_cyc_o=0, wb_addr_o=0, stallreq_o=0 within the same cycle, without waiting for a clock edge.
- Read at 0x0000_0040, slave acks after 3 cycles with 0x3C01_1234, stall_i=0:
  - stallreq_o=1 from the request cycle through the cycle before ack.
  - cpu_data_o=0x3C01_1234 in the ack cycle; IDLE next cycle.
- Write 0xDEAD_BEEF at 0x100, sel=4'b0011:
  - Bus shows we=1, sel=0011, data stable until ack.
  - cpu_data_o=0 in the ack cycle.
- Read acks while stall_i=6'b000111 is held 2 more cycles:
  - FSM sits in WAIT_FOR_STALL with cpu_data_o=rd_buf and stallreq_o=0.
  - Returns to IDLE when stall_i=0.
- flush_i=1 in BUSY while wb_ack_i=1 in the same cycle → flush wins: rd_buf=0, IDLE, stb/cyc=0.
- Back-to-back reads 0x0,0x4,0x8 with zero-wait ack → exactly 3 stb pulses with no overlap, each followed by the correct data.
